mem_seq_checker: RTL and testbench

Parametrised write/readback sequencer for a single-port synchronous RAM with separate address, data_in, wren and data_out ports. On a start pulse it writes a generated pattern to a contiguous address range, reads the range back, and compares each word. It reports a mismatch count and the first failing address. It replaces hand-coded initial-block stimulus: the generic controller sits directly in front of the RAM instance.

---
 rtl/mem_seq_checker.sv | 189 ++++++++++++++++++
 tb/tb_mem_seq_checker.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq_checker.sv
// Write/readback sequencer for a single-port synchronous RAM.
// Fills a wrapping address range with a seed-based pattern, reads it back and tallies mismatches.
module mem_seq_checker #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  invert,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   error_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  first_err_valid
);

  // state | meaning
  // IDLE  | waiting for start, results held
  // WRITE | one pattern word written per cycle
  // READ  | one read issued per cycle, expected data enters the pipeline
  // DRAIN | waiting READ_LATENCY cycles for the last read data
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ONE   = DATA_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO   = '0;
  localparam logic [ADDR_WIDTH:0]   ERR_MAX    = '1;
  localparam logic [1:0]            DRAIN_INIT = 2'(READ_LATENCY - 1);

  state_t                  state;
  logic [1:0]              mode_lat;
  logic [ADDR_WIDTH-1:0]   base_lat;
  logic [ADDR_WIDTH:0]     count_lat;
  logic [DATA_WIDTH-1:0]   seed_lat;
  logic                    inv_lat;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [DATA_WIDTH-1:0]   next_val;
  logic [ADDR_WIDTH:0]     remain;
  logic [1:0]              drain_cnt;
  logic                    pipe_valid [READ_LATENCY];
  logic [ADDR_WIDTH-1:0]   pipe_addr  [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_exp   [READ_LATENCY];

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [DATA_WIDTH-1:0] v,
                                                    input logic inv);
    return inv ? ~v : v;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      mem_address     <= '0;
      mem_data_in     <= '0;
      mem_wren        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error_count     <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
      mode_lat        <= '0;
      base_lat        <= '0;
      count_lat       <= '0;
      seed_lat        <= '0;
      inv_lat         <= 1'b0;
      next_addr       <= '0;
      next_val        <= '0;
      remain          <= '0;
      drain_cnt       <= '0;
      for (int j = 0; j < READ_LATENCY; j++) begin
        pipe_valid[j] <= 1'b0;
        pipe_addr[j]  <= '0;
        pipe_exp[j]   <= '0;
      end
    end else begin
      // During READ, mem_data_in carries the expected word for the address being read.
      pipe_valid[0] <= (state == READ);
      pipe_addr[0]  <= mem_address;
      pipe_exp[0]   <= mem_data_in;
      for (int j = 1; j < READ_LATENCY; j++) begin
        pipe_valid[j] <= pipe_valid[j-1];
        pipe_addr[j]  <= pipe_addr[j-1];
        pipe_exp[j]   <= pipe_exp[j-1];
      end

      if (pipe_valid[READ_LATENCY-1] && (mem_data_out != pipe_exp[READ_LATENCY-1])) begin
        if (error_count != ERR_MAX) error_count <= error_count + CNT_ONE;
        if (!first_err_valid) begin
          first_err_addr  <= pipe_addr[READ_LATENCY-1];
          first_err_valid <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            mode_lat        <= mode;
            base_lat        <= base_addr;
            count_lat       <= count;
            seed_lat        <= seed;
            inv_lat         <= invert;
            error_count     <= '0;
            first_err_addr  <= '0;
            first_err_valid <= 1'b0;
            if (count == CNT_ZERO) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              busy        <= 1'b1;
              mem_address <= base_addr;
              mem_data_in <= pattern(seed, invert);
              next_addr   <= base_addr + ADDR_ONE;
              next_val    <= seed + DATA_ONE;
              remain      <= count - CNT_ONE;
              if (mode == 2'b10) begin
                state    <= READ;
                mem_wren <= 1'b0;
              end else begin
                state    <= WRITE;
                mem_wren <= 1'b1;
              end
            end
          end
        end
        WRITE: begin
          if (remain == CNT_ZERO) begin
            mem_wren <= 1'b0;
            if (mode_lat == 2'b01) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state       <= READ;
              mem_address <= base_lat;
              mem_data_in <= pattern(seed_lat, inv_lat);
              next_addr   <= base_lat + ADDR_ONE;
              next_val    <= seed_lat + DATA_ONE;
              remain      <= count_lat - CNT_ONE;
            end
          end else begin
            mem_address <= next_addr;
            mem_data_in <= pattern(next_val, inv_lat);
            next_addr   <= next_addr + ADDR_ONE;
            next_val    <= next_val + DATA_ONE;
            remain      <= remain - CNT_ONE;
          end
        end
        READ: begin
          if (remain == CNT_ZERO) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_INIT;
          end else begin
            mem_address <= next_addr;
            mem_data_in <= pattern(next_val, inv_lat);
            next_addr   <= next_addr + ADDR_ONE;
            next_val    <= next_val + DATA_ONE;
            remain      <= remain - CNT_ONE;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd0) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_seq_checker.sv
// Bench for mem_seq_checker: two instances (read latency 1 and 3) in front of behavioural RAMs.
// Expected writes and results are queued when a run is launched and popped once the run ends.
module tb_mem_seq_checker;

  typedef struct packed {logic [7:0] addr; logic [7:0] data;} wr_t;
  typedef struct {int cycles; logic [8:0] errs; logic fv; logic [7:0] fa;} res_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [7:0] base_addr, seed;
  logic [8:0] count;
  logic       invert;
  logic       start_a, start_b;

  logic [7:0] addr_a, din_a, dout_a, faddr_a;
  logic       wren_a, busy_a, done_a, fvalid_a;
  logic [8:0] errs_a;
  logic [7:0] addr_b, din_b, dout_b, faddr_b;
  logic       wren_b, busy_b, done_b, fvalid_b;
  logic [8:0] errs_b;

  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];
  logic [7:0] rd_a;
  logic [7:0] rd_b [3];
  logic       poke_en = 1'b0;
  logic [7:0] poke_addr = 8'h00;
  logic [7:0] stuck_b = 8'h00;

  wr_t  exp_wr[$];
  wr_t  obs_wr[$];
  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  mem_seq_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(1)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .mode(mode), .base_addr(base_addr),
    .count(count), .seed(seed), .invert(invert), .mem_address(addr_a), .mem_data_in(din_a),
    .mem_wren(wren_a), .mem_data_out(dout_a), .busy(busy_a), .done(done_a),
    .error_count(errs_a), .first_err_addr(faddr_a), .first_err_valid(fvalid_a));

  mem_seq_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(3)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .mode(mode), .base_addr(base_addr),
    .count(count), .seed(seed), .invert(invert), .mem_address(addr_b), .mem_data_in(din_b),
    .mem_wren(wren_b), .mem_data_out(dout_b), .busy(busy_b), .done(done_b),
    .error_count(errs_b), .first_err_addr(faddr_b), .first_err_valid(fvalid_b));

  // RAM A: one-cycle read latency, with a single-bit corruption hook.
  always @(posedge clock) begin
    if (wren_a) ram_a[addr_a] <= din_a;
    if (poke_en) ram_a[poke_addr] <= ram_a[poke_addr] ^ 8'h01;
    rd_a <= ram_a[addr_a];
  end
  assign dout_a = rd_a;

  // RAM B: three-cycle read latency, read data optionally forced high on stuck bits.
  always @(posedge clock) begin
    if (wren_b) ram_b[addr_b] <= din_b;
    rd_b[0] <= ram_b[addr_b];
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
  end
  assign dout_b = rd_b[2] | stuck_b;

  function automatic void push_writes(input logic [7:0] b, input int c, input logic [7:0] s,
                                      input logic inv);
    logic [7:0] a, v;
    a = b;
    v = s;
    for (int i = 0; i < c; i++) begin
      exp_wr.push_back({a, inv ? ~v : v});
      a = a + 8'd1;
      v = v + 8'd1;
    end
  endfunction

  // Launches one run, scrambles the config inputs afterwards, records writes until done.
  // With poke set, start is re-asserted mid-run and again in the DONE cycle.
  task automatic run_seq(input bit sel, input logic [1:0] m, input logic [7:0] b,
                         input logic [8:0] c, input logic [7:0] s, input logic inv,
                         input bit poke, output int cycles, output bit busy_seen);
    logic w, d, bz;
    logic [7:0] ad, dt;
    mode = m; base_addr = b; count = c; seed = s; invert = inv;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0; start_b = 1'b0;
    mode = 2'($urandom); base_addr = 8'($urandom); count = 9'($urandom);
    seed = 8'($urandom); invert = 1'($urandom);
    cycles = -1;
    busy_seen = 1'b0;
    obs_wr.delete();
    for (int k = 1; k <= 2000; k++) begin
      w  = sel ? wren_b : wren_a;
      d  = sel ? done_b : done_a;
      bz = sel ? busy_b : busy_a;
      ad = sel ? addr_b : addr_a;
      dt = sel ? din_b : din_a;
      if (bz) busy_seen = 1'b1;
      if (w) obs_wr.push_back({ad, dt});
      if (poke && k == 3) begin
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
      if (d) begin
        cycles = k;
        break;
      end
      @(posedge clock); #1;
    end
    if (poke) begin
      if (sel) start_b = 1'b1; else start_a = 1'b1;
    end
    @(posedge clock); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    mode = 2'b00; base_addr = 8'h00; count = 9'd0; seed = 8'h00; invert = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (wren_a !== 1'b0) begin n_fail++; $display("FAIL rst_wren got %0h want 0", wren_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0h want 0", busy_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rst_done got %0h want 0", done_a); end
    n_checks++; if (addr_a !== 8'h00) begin n_fail++; $display("FAIL rst_addr got %0h want 0", addr_a); end
    n_checks++; if (din_a !== 8'h00) begin n_fail++; $display("FAIL rst_din got %0h want 0", din_a); end
    n_checks++; if (errs_a !== 9'd0) begin n_fail++; $display("FAIL rst_errs got %0h want 0", errs_a); end
    n_checks++; if (fvalid_a !== 1'b0) begin n_fail++; $display("FAIL rst_fvalid got %0h want 0", fvalid_a); end
    n_checks++; if (faddr_a !== 8'h00) begin n_fail++; $display("FAIL rst_faddr got %0h want 0", faddr_a); end
    n_checks++; if (wren_b !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL rst_b got wren %0h busy %0h want 0 0", wren_b, busy_b); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_basic;
    int cyc; bit bs; res_t r; wr_t we, wo;
    push_writes(8'h0F, 2, 8'h1E, 1'b0);
    exp_q.push_back('{6, 9'd0, 1'b0, 8'h00});
    run_seq(1'b0, 2'b00, 8'h0F, 9'd2, 8'h1E, 1'b0, 1'b0, cyc, bs);
    r = exp_q.pop_front();
    n_checks++; if (obs_wr.size() != exp_wr.size()) begin n_fail++; $display("FAIL basic_nwr got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      we = exp_wr.pop_front(); wo = obs_wr.pop_front();
      n_checks++; if (wo !== we) begin n_fail++; $display("FAIL basic_wr got %h want %h", wo, we); end
    end
    exp_wr.delete();
    n_checks++; if (cyc !== r.cycles) begin n_fail++; $display("FAIL basic_cycles got %0d want %0d", cyc, r.cycles); end
    n_checks++; if (errs_a !== r.errs) begin n_fail++; $display("FAIL basic_errs got %0d want %0d", errs_a, r.errs); end
    n_checks++; if (fvalid_a !== r.fv) begin n_fail++; $display("FAIL basic_fvalid got %0h want %0h", fvalid_a, r.fv); end
    n_checks++; if (bs !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %0h want 1", bs); end
  endtask

  task automatic test_wrap;
    int cyc; bit bs; res_t r; wr_t we, wo;
    push_writes(8'hFE, 4, 8'h03, 1'b1);
    exp_q.push_back('{10, 9'd0, 1'b0, 8'h00});
    run_seq(1'b0, 2'b11, 8'hFE, 9'd4, 8'h03, 1'b1, 1'b0, cyc, bs);
    r = exp_q.pop_front();
    n_checks++; if (obs_wr.size() != exp_wr.size()) begin n_fail++; $display("FAIL wrap_nwr got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      we = exp_wr.pop_front(); wo = obs_wr.pop_front();
      n_checks++; if (wo !== we) begin n_fail++; $display("FAIL wrap_wr got %h want %h", wo, we); end
    end
    exp_wr.delete();
    n_checks++; if (cyc !== r.cycles) begin n_fail++; $display("FAIL wrap_cycles got %0d want %0d", cyc, r.cycles); end
    n_checks++; if (errs_a !== r.errs) begin n_fail++; $display("FAIL wrap_errs got %0d want %0d", errs_a, r.errs); end
    n_checks++; if (fvalid_a !== r.fv) begin n_fail++; $display("FAIL wrap_fvalid got %0h want %0h", fvalid_a, r.fv); end
    n_checks++; if (bs !== 1'b1) begin n_fail++; $display("FAIL wrap_busy got %0h want 1", bs); end
  endtask

  task automatic test_busy_ignore;
    int cyc; bit bs; res_t r; wr_t we, wo;
    push_writes(8'h80, 6, 8'h5A, 1'b0);
    exp_q.push_back('{7, 9'd0, 1'b0, 8'h00});
    run_seq(1'b0, 2'b01, 8'h80, 9'd6, 8'h5A, 1'b0, 1'b1, cyc, bs);
    r = exp_q.pop_front();
    n_checks++; if (obs_wr.size() != exp_wr.size()) begin n_fail++; $display("FAIL ign_nwr got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      we = exp_wr.pop_front(); wo = obs_wr.pop_front();
      n_checks++; if (wo !== we) begin n_fail++; $display("FAIL ign_wr got %h want %h", wo, we); end
    end
    exp_wr.delete();
    n_checks++; if (cyc !== r.cycles) begin n_fail++; $display("FAIL ign_cycles got %0d want %0d", cyc, r.cycles); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || wren_a !== 1'b0) begin
        n_fail++; $display("FAIL ign_idle got busy %0h done %0h wren %0h want 0 0 0", busy_a, done_a, wren_a);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_corrupt;
    int cyc; bit bs; res_t r; wr_t we, wo;
    push_writes(8'hEE, 6, 8'h40, 1'b0);
    exp_q.push_back('{7, 9'd0, 1'b0, 8'h00});
    run_seq(1'b0, 2'b01, 8'hEE, 9'd6, 8'h40, 1'b0, 1'b0, cyc, bs);
    r = exp_q.pop_front();
    n_checks++; if (obs_wr.size() != exp_wr.size()) begin n_fail++; $display("FAIL fill_nwr got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      we = exp_wr.pop_front(); wo = obs_wr.pop_front();
      n_checks++; if (wo !== we) begin n_fail++; $display("FAIL fill_wr got %h want %h", wo, we); end
    end
    exp_wr.delete();
    n_checks++; if (cyc !== r.cycles) begin n_fail++; $display("FAIL fill_cycles got %0d want %0d", cyc, r.cycles); end
    poke_addr = 8'hF0; poke_en = 1'b1;
    @(posedge clock); #1;
    poke_en = 1'b0;
    exp_q.push_back('{8, 9'd1, 1'b1, 8'hF0});
    run_seq(1'b0, 2'b10, 8'hEE, 9'd6, 8'h40, 1'b0, 1'b0, cyc, bs);
    r = exp_q.pop_front();
    n_checks++; if (obs_wr.size() != 0) begin n_fail++; $display("FAIL verify_nwr got %0d want 0", obs_wr.size()); end
    n_checks++; if (cyc !== r.cycles) begin n_fail++; $display("FAIL verify_cycles got %0d want %0d", cyc, r.cycles); end
    n_checks++; if (errs_a !== r.errs) begin n_fail++; $display("FAIL verify_errs got %0d want %0d", errs_a, r.errs); end
    n_checks++; if (fvalid_a !== r.fv) begin n_fail++; $display("FAIL verify_fvalid got %0h want %0h", fvalid_a, r.fv); end
    n_checks++; if (faddr_a !== r.fa) begin n_fail++; $display("FAIL verify_faddr got %0h want %0h", faddr_a, r.fa); end
  endtask

  task automatic test_zero_count;
    int cyc; bit bs; res_t r;
    exp_q.push_back('{1, 9'd0, 1'b0, 8'h00});
    run_seq(1'b0, 2'b00, 8'h33, 9'd0, 8'h99, 1'b0, 1'b0, cyc, bs);
    r = exp_q.pop_front();
    n_checks++; if (obs_wr.size() != 0) begin n_fail++; $display("FAIL zero_nwr got %0d want 0", obs_wr.size()); end
    n_checks++; if (cyc !== r.cycles) begin n_fail++; $display("FAIL zero_cycles got %0d want %0d", cyc, r.cycles); end
    n_checks++; if (errs_a !== r.errs) begin n_fail++; $display("FAIL zero_errs got %0d want %0d", errs_a, r.errs); end
    n_checks++; if (fvalid_a !== r.fv) begin n_fail++; $display("FAIL zero_fvalid got %0h want %0h", fvalid_a, r.fv); end
    n_checks++; if (faddr_a !== r.fa) begin n_fail++; $display("FAIL zero_faddr got %0h want %0h", faddr_a, r.fa); end
    n_checks++; if (bs !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %0h want 0", bs); end
  endtask

  task automatic test_latency3;
    int cyc; bit bs; res_t r; wr_t we, wo;
    stuck_b = 8'h80;
    push_writes(8'h20, 8, 8'h00, 1'b0);
    exp_q.push_back('{20, 9'd8, 1'b1, 8'h20});
    run_seq(1'b1, 2'b00, 8'h20, 9'd8, 8'h00, 1'b0, 1'b0, cyc, bs);
    r = exp_q.pop_front();
    stuck_b = 8'h00;
    n_checks++; if (obs_wr.size() != exp_wr.size()) begin n_fail++; $display("FAIL lat3_nwr got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      we = exp_wr.pop_front(); wo = obs_wr.pop_front();
      n_checks++; if (wo !== we) begin n_fail++; $display("FAIL lat3_wr got %h want %h", wo, we); end
    end
    exp_wr.delete();
    n_checks++; if (cyc !== r.cycles) begin n_fail++; $display("FAIL lat3_cycles got %0d want %0d", cyc, r.cycles); end
    n_checks++; if (errs_b !== r.errs) begin n_fail++; $display("FAIL lat3_errs got %0d want %0d", errs_b, r.errs); end
    n_checks++; if (fvalid_b !== r.fv) begin n_fail++; $display("FAIL lat3_fvalid got %0h want %0h", fvalid_b, r.fv); end
    n_checks++; if (faddr_b !== r.fa) begin n_fail++; $display("FAIL lat3_faddr got %0h want %0h", faddr_b, r.fa); end
  endtask

  task automatic test_reset_mid;
    int cyc; bit bs; bit found; res_t r; wr_t we, wo;
    mode = 2'b00; base_addr = 8'h50; count = 9'd10; seed = 8'h11; invert = 1'b0;
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (wren_a === 1'b1 && addr_a === 8'h53) begin
        found = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL mid_reach got %0h want 1", found); end
    n_checks++; if (din_a !== 8'h14 || busy_a !== 1'b1) begin n_fail++; $display("FAIL mid_idx3 got din %0h busy %0h want 14 1", din_a, busy_a); end
    reset = 1'b1;
    @(posedge clock); #1;
    n_checks++; if (wren_a !== 1'b0) begin n_fail++; $display("FAIL mid_wren got %0h want 0", wren_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %0h want 0", busy_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL mid_done got %0h want 0", done_a); end
    n_checks++; if (addr_a !== 8'h00) begin n_fail++; $display("FAIL mid_addr got %0h want 0", addr_a); end
    reset = 1'b0;
    @(posedge clock); #1;
    n_checks++; if (done_a !== 1'b0 || wren_a !== 1'b0) begin n_fail++; $display("FAIL mid_quiet got done %0h wren %0h want 0 0", done_a, wren_a); end
    push_writes(8'h60, 2, 8'h70, 1'b0);
    exp_q.push_back('{3, 9'd0, 1'b0, 8'h00});
    run_seq(1'b0, 2'b01, 8'h60, 9'd2, 8'h70, 1'b0, 1'b0, cyc, bs);
    r = exp_q.pop_front();
    n_checks++; if (obs_wr.size() != exp_wr.size()) begin n_fail++; $display("FAIL restart_nwr got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      we = exp_wr.pop_front(); wo = obs_wr.pop_front();
      n_checks++; if (wo !== we) begin n_fail++; $display("FAIL restart_wr got %h want %h", wo, we); end
    end
    exp_wr.delete();
    n_checks++; if (cyc !== r.cycles) begin n_fail++; $display("FAIL restart_cycles got %0d want %0d", cyc, r.cycles); end
    n_checks++; if (bs !== 1'b1) begin n_fail++; $display("FAIL restart_busy got %0h want 1", bs); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_busy_ignore();
    test_corrupt();
    test_zero_count();
    test_latency3();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
